apb_spi_slave: RTL and testbench
================================

# apb_spi_slave

APB-attached SPI slave (target) peripheral: the responder end of the SPI link driven by the existing APB SPI master. An external master drives CS_N/SCK/MOSI. The block shifts bytes in and out in all four CPOL/CPHA modes, with MSB- or LSB-first order. Single-byte TX and RX buffers, status flags and a level interrupt are exposed to the Cortex-M0 through a 16-byte APB register window.

## Interface
- Parameters: none.
- PCLK  in  1  sole clock; all logic on posedge.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  32  only [3:0] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  registered read data.
- CS_N  in  1  slave select from the external master, active-low, asynchronous to PCLK.
- SCK  in  1  serial clock, asynchronous to PCLK.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- MISO_OE  out  1  MISO output enable for the pad; 1 only while selected and enabled.
- SPI_IRQ  out  1  level interrupt.

## Operation
- Register map (PADDR[3:0]):
  - 0x0 SR: bit0 RXNE, bit1 TXE, bit2 OVR (W1C), bit3 UDR (W1C), bit4 BUSY (synchronized CS_N low). All other bits read 0.
  - 0x4 DR: a write loads TXBUF[7:0] and clears TXE. A read returns RXBUF in [7:0] and clears RXNE.
  - 0x8 CR: bit0 EN, bit1 IRQ_EN, bit2 CPOL, bit3 CPHA, bit4 FIRSTBIT (0 = MSB first).
  - 0xC: reserved; reads 0, writes ignored.
- APB protocol:
  - A write takes effect when PSEL&PWRITE&PENABLE.
  - A read is captured into PRDATA in the setup phase (PSEL&!PWRITE&!PENABLE). The DR side effect (RXNE clear) also happens in that cycle.
- Synchronization: CS_N, SCK and MOSI each pass through a 2-flop synchronizer. Edges are detected against a third register.
- Sample and shift edges:
  - Leading edge is rising if CPOL=0, falling if CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- State: tx_sh[7:0], rx_sh[7:0], bit_cnt[2:0], and tx_valid (the loaded byte came from TXBUF).
- Loading tx_sh:
  - A load copies TXBUF when TXE=0 (tx_valid=1). When TXE=1 it loads 0xFF (tx_valid=0).
  - CS_N falling edge with EN=1: bit_cnt<=0. If CPHA=0, tx_sh is loaded at this point.
  - Shift edge with bit_cnt==0 and not the CPHA=0 first byte: load. Otherwise shift tx_sh toward the output end.
- Sample edge: MOSI is shifted into rx_sh, then bit_cnt increments.
  - First sample of a byte: if tx_valid, set TXE (TXBUF released); otherwise set UDR.
  - 8th sample (bit_cnt wraps 7->0): if RXNE=0, RXBUF<=byte and RXNE<=1. If RXNE=1, set OVR and discard the new byte.
- MISO output:
  - MISO = tx_sh[7] when FIRSTBIT=0, tx_sh[0] when FIRSTBIT=1.
  - MISO_OE = EN & synchronized CS_N low.
  - MISO = 0 whenever MISO_OE=0.
- CS_N rising edge: bit_cnt<=0. A partial RX byte is discarded with no flag change.
- EN=0: SPI edges are ignored, bit_cnt is held at 0, and registers remain accessible.
- CR mode bits may only be changed while CS_N is high. Changing them during a transfer is unsupported.
- SPI_IRQ = IRQ_EN & (RXNE | OVR | UDR), registered.
- Simultaneous events:
  - DR read and byte completion in the same cycle: RXBUF is updated, RXNE stays 1, no OVR.
  - DR write and TXBUF release in the same cycle: the write wins, TXE=0.
  - W1C and flag set in the same cycle: the set wins.

## Timing
- Reset values: PRDATA=0, MISO=0, MISO_OE=0, SPI_IRQ=0, CR=0, TXBUF=0, RXBUF=0, SR=0x02 (TXE=1). Synchronizers are also reset.
- An SCK/CS_N pin transition is acted on at the 3rd PCLK posedge after it. MISO changes at that same edge.
- Minimum SCK high and low time is 4 PCLK periods each.
- The first CPHA=0 leading edge must occur at least 4 PCLK after CS_N falls.
- A flag is visible in SR on the PCLK after its set edge. SPI_IRQ follows one cycle later.
- PRDATA is valid in the APB access phase, with zero wait states.
- Reset asserted mid-transfer returns everything to reset values immediately. The partial byte is lost.

## Test plan
- Mode 0, MSB first: CR=0x01, DR<=0xA5, master sends 0x3C. Master receives 0xA5. SR reads 0x13 during the transfer and 0x03 after CS_N rises. DR read returns 0x3C, then SR=0x02.
- Mode 3, LSB first: CR=0x1D, DR<=0x81, master sends 0x5A in LSB-first order. Master receives 0x81 (bit order 1,0,0,0,0,0,0,1). DR read returns 0x5A.
- Overrun plus IRQ: CR=0x03, master sends 0x11 then 0x22 with no read. OVR=1 and SPI_IRQ=1. DR read returns 0x11. Writing SR 0x04 clears OVR, and SPI_IRQ goes 0 within 2 cycles.
- Underrun: TXE=1, master sends 0x00 in mode 1 (CR=0x09). Master receives 0xFF, UDR=1. Writing SR 0x08 clears UDR.
- Abort: CS_N rises after 4 bits, then a full byte 0x96 is sent. RXNE stays 0 through the abort, and RXBUF=0x96 after the full byte.
- Reset mid-transfer: PRESETn low after 3 bits. MISO_OE=0, SR=0x02, PRDATA=0. A following full transfer of 0xC3 completes correctly.

Source files
------------

// File: rtl/apb_spi_slave_if.sv
// APB completer-side bus bundle used by apb_spi_slave.
interface apb_spi_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  // Handshake: zero-wait-state APB with no PREADY. A transfer is one setup cycle
  // (PSEL=1, PENABLE=0) followed by one access cycle (PSEL=1, PENABLE=1), and every
  // access completes in that access cycle. Reads are captured into PRDATA at the end
  // of setup; writes take effect at the end of access.
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/apb_spi_slave.sv
// SPI target with an APB register window: SR/DR/CR, single-byte TX and RX buffers,
// all four CPOL/CPHA modes, MSB/LSB first, level interrupt. SPI pins are oversampled
// by PCLK through 2-flop synchronizers plus one edge-detect stage.
module apb_spi_slave (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_spi_slave_if.slave apb,
  input  logic           CS_N,
  input  logic           SCK,
  input  logic           MOSI,
  output logic           MISO,
  output logic           MISO_OE,
  output logic           SPI_IRQ
);
  localparam logic [3:0] ADDR_SR = 4'h0;
  localparam logic [3:0] ADDR_DR = 4'h4;
  localparam logic [3:0] ADDR_CR = 4'h8;

  // [0],[1] are the synchronizer, [2] is the edge-detect reference
  logic [2:0] cs_q, sck_q;
  logic [1:0] mosi_q;

  logic [4:0] cr_q, cr_d;
  logic [7:0] txbuf_q, txbuf_d, rxbuf_q, rxbuf_d;
  logic       rxne_q, rxne_d, txe_q, txe_d, ovr_q, ovr_d, udr_q, udr_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_valid_q, tx_valid_d;
  logic [31:0] prdata_q, prdata_d;
  logic       irq_q;

  logic en, irq_en, cpol, cpha, lsb_first;
  logic cs_fall, cs_rise, sck_rise, sck_fall, lead_edge, trail_edge;
  logic spi_active, shift_edge, sample_edge;
  logic set_txe, set_udr, byte_done;
  logic [7:0] load_val, rx_next;
  logic wr_en, rd_setup, wr_sr, wr_dr, wr_cr, rd_dr;
  logic unused_bits;

  assign en        = cr_q[0];
  assign irq_en    = cr_q[1];
  assign cpol      = cr_q[2];
  assign cpha      = cr_q[3];
  assign lsb_first = cr_q[4];

  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];

  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  // SCK only counts while enabled and firmly selected (not on the CS_N rise cycle)
  assign spi_active  = en & ~cs_q[2] & ~cs_q[1];
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  // Empty TX buffer sends all-ones and flags the byte as not owned by TXBUF
  assign load_val = txe_q ? 8'hFF : txbuf_q;
  assign rx_next  = lsb_first ? {mosi_q[1], rx_sh_q[7:1]} : {rx_sh_q[6:0], mosi_q[1]};

  assign wr_en    = apb.PSEL & apb.PWRITE & apb.PENABLE;
  assign rd_setup = apb.PSEL & ~apb.PWRITE & ~apb.PENABLE;
  assign wr_sr    = wr_en & (apb.PADDR[3:0] == ADDR_SR);
  assign wr_dr    = wr_en & (apb.PADDR[3:0] == ADDR_DR);
  assign wr_cr    = wr_en & (apb.PADDR[3:0] == ADDR_CR);
  assign rd_dr    = rd_setup & (apb.PADDR[3:0] == ADDR_DR);

  assign unused_bits = ^{apb.PADDR[31:4], apb.PWDATA[31:8]};

  assign MISO_OE    = en & ~cs_q[2];
  assign MISO       = MISO_OE & (lsb_first ? tx_sh_q[0] : tx_sh_q[7]);
  assign SPI_IRQ    = irq_q;
  assign apb.PRDATA = prdata_q;

  // Pin synchronizers; CS_N idles high so no spurious select edge leaves reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], CS_N};
      sck_q  <= {sck_q[1:0], SCK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  // Serial engine: select edges, shift/load of tx_sh, sampling into rx_sh
  always_comb begin
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    tx_valid_d = tx_valid_q;
    set_txe    = 1'b0;
    set_udr    = 1'b0;
    byte_done  = 1'b0;
    if (!en || cs_rise) begin
      bit_cnt_d = 3'd0;
    end else if (cs_fall) begin
      bit_cnt_d = 3'd0;
      if (!cpha) begin
        tx_sh_d    = load_val;
        tx_valid_d = ~txe_q;
      end
    end else if (spi_active) begin
      if (shift_edge) begin
        // bit_cnt==0 on a shift edge means a byte boundary: fetch the next byte
        if (bit_cnt_q == 3'd0) begin
          tx_sh_d    = load_val;
          tx_valid_d = ~txe_q;
        end else if (lsb_first) begin
          tx_sh_d = {1'b1, tx_sh_q[7:1]};
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b1};
        end
      end
      if (sample_edge) begin
        rx_sh_d   = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd0) begin
          if (tx_valid_q) set_txe = 1'b1;
          else            set_udr = 1'b1;
        end
        if (bit_cnt_q == 3'd7) byte_done = 1'b1;
      end
    end
  end

  // Register file and flags; hardware set beats software clear
  always_comb begin
    cr_d    = wr_cr ? apb.PWDATA[4:0] : cr_q;
    txbuf_d = wr_dr ? apb.PWDATA[7:0] : txbuf_q;
    txe_d   = txe_q;
    if (set_txe) txe_d = 1'b1;
    if (wr_dr)   txe_d = 1'b0;
    rxbuf_d = rxbuf_q;
    rxne_d  = rxne_q;
    ovr_d   = ovr_q;
    udr_d   = udr_q;
    if (rd_dr) rxne_d = 1'b0;
    if (wr_sr && apb.PWDATA[2]) ovr_d = 1'b0;
    if (wr_sr && apb.PWDATA[3]) udr_d = 1'b0;
    // A DR read in the completion cycle frees the buffer for the new byte
    if (byte_done) begin
      if (!rxne_q || rd_dr) begin
        rxbuf_d = rx_next;
        rxne_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (set_udr) udr_d = 1'b1;
    prdata_d = prdata_q;
    if (rd_setup) begin
      case (apb.PADDR[3:0])
        ADDR_SR: prdata_d = {27'd0, ~cs_q[2], udr_q, ovr_q, txe_q, rxne_q};
        ADDR_DR: prdata_d = {24'd0, rxbuf_q};
        ADDR_CR: prdata_d = {27'd0, cr_q};
        default: prdata_d = 32'd0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr_q       <= 5'd0;
      txbuf_q    <= 8'd0;
      rxbuf_q    <= 8'd0;
      rxne_q     <= 1'b0;
      txe_q      <= 1'b1;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      tx_valid_q <= 1'b0;
      prdata_q   <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      cr_q       <= cr_d;
      txbuf_q    <= txbuf_d;
      rxbuf_q    <= rxbuf_d;
      rxne_q     <= rxne_d;
      txe_q      <= txe_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_valid_q <= tx_valid_d;
      prdata_q   <= prdata_d;
      irq_q      <= irq_en & (rxne_q | ovr_q | udr_q);
    end
  end
endmodule

// File: tb/tb_apb_spi_slave.sv
// Bench for apb_spi_slave: vector table, directed corner sequences, and a
// randomized session loop scored against a byte-level model of the peripheral.
module tb_apb_spi_slave;
  localparam int HALF = 60;

  logic PCLK = 1'b0;
  logic PRESETn;
  logic CS_N, SCK, MOSI;
  logic MISO, MISO_OE, SPI_IRQ;

  apb_spi_slave_if apb ();

  apb_spi_slave dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb),
    .CS_N(CS_N), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .SPI_IRQ(SPI_IRQ)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic cpol, cpha, lsb;

  // byte-level model state
  logic [4:0] m_cr;
  logic [7:0] m_txbuf, m_rxbuf;
  logic m_txe, m_rxne, m_ovr, m_udr;

  typedef struct {
    logic [7:0] cr;
    bit         load;
    logic [7:0] dr;
    logic [7:0] mosi;
    logic [7:0] miso;
    logic [7:0] sr_mid;
    logic [7:0] sr_end;
    logic [7:0] rx;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 32'd0; apb.PWDATA = 32'd0;
    CS_N = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
  endtask

  // driver tasks: APB
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PENABLE = 1'b0;
    apb.PADDR = {28'd0, addr}; apb.PWDATA = data;
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    @(posedge PCLK); #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0;
    apb.PADDR = {28'd0, addr};
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    data = apb.PRDATA;
    @(posedge PCLK); #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic set_mode(input logic [7:0] cr);
    cpol = cr[2]; cpha = cr[3]; lsb = cr[4];
    apb_write(4'h8, {24'd0, cr});
  endtask

  // driver tasks: SPI master
  task automatic spi_begin();
    SCK = cpol;
    #50 CS_N = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #HALF CS_N = 1'b1;
    #80;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    logic [7:0] r;
    int bi;
    r = 8'd0;
    for (int i = 0; i < n; i++) begin
      bi = lsb ? i : 7 - i;
      if (!cpha) begin
        MOSI = tx[bi];
        #HALF SCK = ~cpol;
        r[bi] = MISO;
        #HALF SCK = cpol;
      end else begin
        SCK = ~cpol;
        MOSI = tx[bi];
        #HALF SCK = cpol;
        r[bi] = MISO;
        #HALF;
      end
    end
    rx = r;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_begin();
    spi_bits(tx, 8, rx);
    spi_end();
  endtask

  // model: one serial byte, full or cut short by CS_N rising
  task automatic model_byte(input logic [7:0] mosi_b, input bit full);
    logic [7:0] out_b;
    if (!m_cr[0]) begin
      if (full) exp_q.push_back(8'h00);
    end else begin
      out_b = m_txe ? 8'hFF : m_txbuf;
      if (m_txe) m_udr = 1'b1;
      else       m_txe = 1'b1;
      if (full) begin
        exp_q.push_back(out_b);
        if (m_rxne) m_ovr = 1'b1;
        else begin
          m_rxbuf = mosi_b;
          m_rxne  = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_sr();
    return {28'd0, m_udr, m_ovr, m_txe, m_rxne};
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0] rx, d, e;
    int nb, nbits;
    bit ab;

    //            cr     ld    dr     mosi   miso   mid    end    rx
    vecs[0] = '{8'h01, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h13, 8'h03, 8'h3C};
    vecs[1] = '{8'h1D, 1'b1, 8'h81, 8'h5A, 8'h81, 8'h13, 8'h03, 8'h5A};
    vecs[2] = '{8'h09, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h1B, 8'h0B, 8'h00};
    vecs[3] = '{8'h05, 1'b1, 8'h3C, 8'hC3, 8'h3C, 8'h13, 8'h03, 8'hC3};
    vecs[4] = '{8'h11, 1'b1, 8'h01, 8'h80, 8'h01, 8'h13, 8'h03, 8'h80};
    vecs[5] = '{8'h15, 1'b1, 8'h0F, 8'hF0, 8'h0F, 8'h13, 8'h03, 8'hF0};
    vecs[6] = '{8'h00, 1'b1, 8'h55, 8'hAA, 8'h00, 8'h10, 8'h00, 8'h00};
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;

    // reset values
    do_reset();
    check("rst_prdata", apb.PRDATA, 32'd0);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_miso_oe", {31'd0, MISO_OE}, 32'd0);
    check("rst_irq", {31'd0, SPI_IRQ}, 32'd0);
    apb_read(4'h0, r); check("rst_sr", r, 32'h02);
    apb_read(4'h8, r); check("rst_cr", r, 32'h00);
    apb_read(4'h4, r); check("rst_dr", r, 32'h00);
    apb_write(4'hC, 32'hFFFF_FFFF);
    apb_read(4'hC, r); check("reserved", r, 32'h00);

    // vector table: one byte per vector from reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_mode(vecs[v].cr);
      if (vecs[v].load) apb_write(4'h4, {24'd0, vecs[v].dr});
      spi_begin();
      spi_bits(vecs[v].mosi, 8, rx);
      check($sformatf("vec%0d_miso", v), {24'd0, rx}, {24'd0, vecs[v].miso});
      apb_read(4'h0, r); check($sformatf("vec%0d_sr_mid", v), r, {24'd0, vecs[v].sr_mid});
      spi_end();
      apb_read(4'h0, r); check($sformatf("vec%0d_sr_end", v), r, {24'd0, vecs[v].sr_end});
      apb_read(4'h4, r); check($sformatf("vec%0d_rx", v), r, {24'd0, vecs[v].rx});
      apb_read(4'h0, r); check($sformatf("vec%0d_sr_rd", v), r, {24'd0, vecs[v].sr_end & 8'hFE});
    end

    // overrun plus interrupt
    do_reset();
    set_mode(8'h03);
    apb_write(4'h4, 32'hAA);
    spi_byte(8'h11, rx); check("ovr_miso0", {24'd0, rx}, 32'hAA);
    apb_write(4'h4, 32'hBB);
    spi_byte(8'h22, rx); check("ovr_miso1", {24'd0, rx}, 32'hBB);
    apb_read(4'h0, r); check("ovr_sr", r, 32'h07);
    check("ovr_irq", {31'd0, SPI_IRQ}, 32'd1);
    apb_read(4'h4, r); check("ovr_dr", r, 32'h11);
    apb_write(4'h0, 32'h04);
    repeat (2) @(posedge PCLK);
    #1 check("ovr_irq_clr", {31'd0, SPI_IRQ}, 32'd0);
    apb_read(4'h0, r); check("ovr_sr_clr", r, 32'h02);

    // underrun and its W1C
    do_reset();
    set_mode(8'h09);
    spi_byte(8'h00, rx); check("udr_miso", {24'd0, rx}, 32'hFF);
    apb_read(4'h0, r); check("udr_sr", r, 32'h0B);
    apb_write(4'h0, 32'h08);
    apb_read(4'h0, r); check("udr_sr_clr", r, 32'h03);

    // abort after 4 bits, then a full byte
    do_reset();
    set_mode(8'h01);
    apb_write(4'h4, 32'h77);
    spi_begin();
    spi_bits(8'hF0, 4, rx);
    spi_end();
    apb_read(4'h0, r); check("abort_sr", r, 32'h02);
    spi_byte(8'h96, rx);
    apb_read(4'h4, r); check("abort_dr", r, 32'h96);

    // reset in the middle of a transfer
    do_reset();
    set_mode(8'h01);
    apb_write(4'h4, 32'h5E);
    apb_read(4'h8, r); check("rstmid_cr", r, 32'h01);
    spi_begin();
    spi_bits(8'hC3, 3, rx);
    PRESETn = 1'b0;
    #1;
    check("rstmid_oe", {31'd0, MISO_OE}, 32'd0);
    check("rstmid_miso", {31'd0, MISO}, 32'd0);
    check("rstmid_prdata", apb.PRDATA, 32'd0);
    CS_N = 1'b1; SCK = 1'b0;
    #30 PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    apb_read(4'h0, r); check("rstmid_sr", r, 32'h02);
    set_mode(8'h01);
    apb_write(4'h4, 32'h5E);
    spi_byte(8'hC3, rx); check("rstmid_miso_byte", {24'd0, rx}, 32'h5E);
    apb_read(4'h4, r); check("rstmid_dr", r, 32'hC3);

    // randomized sessions against the byte-level model
    do_reset();
    m_cr = 5'd0; m_txbuf = 8'd0; m_rxbuf = 8'd0;
    m_txe = 1'b1; m_rxne = 1'b0; m_ovr = 1'b0; m_udr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      d = 8'($urandom_range(0, 31));
      d[0] = ($urandom_range(0, 5) != 0);
      set_mode(d);
      m_cr = d[4:0];
      if ($urandom_range(0, 2) != 0) begin
        d = 8'($urandom);
        apb_write(4'h4, {24'd0, d});
        m_txbuf = d; m_txe = 1'b0;
      end
      nb = $urandom_range(1, 2);
      ab = ($urandom_range(0, 4) == 0);
      spi_begin();
      for (int b = 0; b < nb; b++) begin
        d = 8'($urandom);
        model_byte(d, 1'b1);
        spi_bits(d, 8, rx);
        if (exp_q.size() == 0) begin
          check("rand_queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_miso", {24'd0, rx}, {24'd0, e});
        end
      end
      if (ab) begin
        d = 8'($urandom);
        nbits = $urandom_range(1, 7);
        spi_bits(d, nbits, rx);
        model_byte(d, 1'b0);
      end
      spi_end();
      apb_read(4'h0, r); check("rand_sr", r, model_sr());
      if ($urandom_range(0, 1) == 1) begin
        apb_read(4'h4, r); check("rand_dr", r, {24'd0, m_rxbuf});
        m_rxne = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        d = 8'($urandom_range(0, 15));
        apb_write(4'h0, {24'd0, d});
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_udr = 1'b0;
      end
      repeat (2) @(posedge PCLK);
      #1 check("rand_irq", {31'd0, SPI_IRQ}, {31'd0, m_cr[1] & (m_rxne | m_ovr | m_udr)});
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
